// File: rtl/hs_arb_pkg.sv
// Shared types and default constants for the hiscore work-RAM arbiter.
package hs_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAUSE_REQ,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

    localparam int unsigned HALT_TIMEOUT_DEF = 1023;
    localparam logic [31:0] DIM_CYCLES_DEF   = 32'h1C9C3800;  // 10 s at 48 MHz

endpackage

// File: rtl/pause_dim_timer.sv
// Counts consecutive paused cycles and requests a video dim once DIM_CYCLES is reached.
module pause_dim_timer #(
    parameter logic [31:0] DIM_CYCLES = 32'd100
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic active,
    output logic dim
);

    logic [31:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (cnt < DIM_CYCLES) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign dim = (cnt >= DIM_CYCLES);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Hands the CPU work-RAM port to the hiscore engine once the CPU is halted (or a timeout expires).
// Optional video dim after a long pause is enabled by defining HS_RAM_ARBITER_DIM_EN.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = HALT_TIMEOUT_DEF,
    parameter logic [31:0] DIM_CYCLES   = DIM_CYCLES_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs_req,
    input  logic [15:0] hs_address,
    input  logic [7:0]  hs_data_in,
    input  logic        hs_write,
    output logic        hs_grant,
    output logic [7:0]  hs_data_out,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    output logic [7:0]  cpu_dout,
    input  logic        cpu_halted,
    input  logic        user_pause,
    output logic        cpu_pause,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        halt_timeout,
    output logic        dim_video
);

    localparam logic [31:0] HALT_LIMIT = 32'(HALT_TIMEOUT);

    arb_state_t  state, state_nxt;
    logic [31:0] wait_cnt, wait_nxt;
    logic        timeout_set;
    logic        hs_owns;

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_req) begin
                    state_nxt = ST_PAUSE_REQ;
                    wait_nxt  = '0;
                end
            end
            ST_PAUSE_REQ: begin
                // A dropped request beats a halt arriving in the same cycle.
                if (!hs_req) begin
                    state_nxt = ST_RELEASE;
                end else begin
                    wait_nxt = wait_cnt + 32'd1;
                    if (cpu_halted) begin
                        state_nxt = ST_GRANT;
                    end else if (wait_cnt + 32'd1 >= HALT_LIMIT) begin
                        state_nxt   = ST_GRANT;
                        timeout_set = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (!hs_req) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            hs_grant     <= 1'b0;
            halt_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            hs_grant     <= (state_nxt == ST_GRANT);
            halt_timeout <= halt_timeout | timeout_set;
        end
    end

    // While reset is held the CPU path is live regardless of the stale state register.
    assign hs_owns   = (state == ST_GRANT) && !reset;
    assign cpu_pause = user_pause | (!reset && (state != ST_IDLE));

    always_comb begin
        ram_addr = cpu_address;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        if (hs_owns) begin
            ram_addr = hs_address;
            ram_din  = hs_data_in;
            ram_we   = hs_write;
        end else if (reset || state == ST_IDLE) begin
            ram_we   = cpu_we;
        end
    end

    assign hs_data_out = ram_dout;
    assign cpu_dout    = ram_dout;

`ifdef HS_RAM_ARBITER_DIM_EN
    pause_dim_timer #(
        .DIM_CYCLES(DIM_CYCLES)
    ) u_dim (
        .clk_sys (clk_sys),
        .reset   (reset),
        .active  (cpu_pause),
        .dim     (dim_video)
    );
`else
    // DIM_CYCLES has no effect in this build; the reduction keeps it referenced.
    assign dim_video = 1'b0 & (|DIM_CYCLES);
`endif

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench for hs_ram_arbiter: a behavioural ownership model predicts every cycle's outputs.
module tb_hs_ram_arbiter;

    localparam int          HT = 15;
    localparam logic [31:0] DC = 32'd100;

    logic        clk_sys = 1'b0;
    logic        reset, hs_req, hs_write, cpu_we, cpu_halted, user_pause;
    logic [15:0] hs_address, cpu_address;
    logic [7:0]  hs_data_in, cpu_din, ram_dout;
    logic        hs_grant, cpu_pause, ram_we, halt_timeout, dim_video;
    logic [7:0]  hs_data_out, cpu_dout, ram_din;
    logic [15:0] ram_addr;

    hs_ram_arbiter #(.HALT_TIMEOUT(HT), .DIM_CYCLES(DC)) dut (
        .clk_sys(clk_sys), .reset(reset), .hs_req(hs_req), .hs_address(hs_address),
        .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_grant(hs_grant),
        .hs_data_out(hs_data_out), .cpu_address(cpu_address), .cpu_din(cpu_din),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_halted(cpu_halted),
        .user_pause(user_pause), .cpu_pause(cpu_pause), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .halt_timeout(halt_timeout), .dim_video(dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        cpu_pause, hs_grant, halt_timeout, dim_video, ram_we;
        logic [15:0] ram_addr;
        logic [7:0]  ram_din, rd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0, n_pass = 0;

    // Model: who holds the RAM and how long things have been going on.
    bit m_req, m_own, m_rel, m_to;
    int m_wait, m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    always @(negedge clk_sys) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_pause",    32'(cpu_pause),    32'(e.cpu_pause));
            chk("hs_grant",     32'(hs_grant),     32'(e.hs_grant));
            chk("halt_timeout", 32'(halt_timeout), 32'(e.halt_timeout));
            chk("dim_video",    32'(dim_video),    32'(e.dim_video));
            chk("ram_we",       32'(ram_we),       32'(e.ram_we));
            chk("ram_addr",     32'(ram_addr),     32'(e.ram_addr));
            chk("ram_din",      32'(ram_din),      32'(e.ram_din));
            chk("hs_data_out",  32'(hs_data_out),  32'(e.rd));
            chk("cpu_dout",     32'(cpu_dout),     32'(e.rd));
        end
    end

    task automatic cyc(input bit r, input bit hr, input bit ch, input bit hw, input bit up,
                       input bit cw, input logic [15:0] ha, input logic [7:0] hd);
        exp_t x;
        bit   busy, own;
        reset       = r;   hs_req     = hr; cpu_halted = ch;
        hs_write    = hw;  user_pause = up; cpu_we     = cw;
        hs_address  = ha;  hs_data_in = hd;
        cpu_address = 16'($urandom); cpu_din = 8'($urandom); ram_dout = 8'($urandom);
        busy = m_req | m_own | m_rel;
        own  = !r && m_own;
        x.cpu_pause    = up | (!r && busy);
        x.hs_grant     = m_own;
        x.halt_timeout = m_to;
`ifdef HS_RAM_ARBITER_DIM_EN
        x.dim_video    = (m_run >= int'(DC));
`else
        x.dim_video    = 1'b0;
`endif
        x.ram_addr = own ? ha : cpu_address;
        x.ram_din  = own ? hd : cpu_din;
        x.ram_we   = own ? hw : ((r || !busy) ? cw : 1'b0);
        x.rd       = ram_dout;
        q.push_back(x);
        @(posedge clk_sys);
        if (r) begin
            m_req = 0; m_own = 0; m_rel = 0; m_to = 0; m_wait = 0; m_run = 0;
        end else begin
            if (x.cpu_pause) m_run = (m_run < int'(DC)) ? m_run + 1 : m_run;
            else             m_run = 0;
            if (m_rel) m_rel = 0;
            else if (m_req) begin
                if (!hr) begin m_req = 0; m_rel = 1; end
                else begin
                    m_wait++;
                    if (ch || m_wait >= HT) begin
                        m_req = 0; m_own = 1;
                        if (!ch) m_to = 1;
                    end
                end
            end else if (m_own) begin
                if (!hr) begin m_own = 0; m_rel = 1; end
            end else if (hr) begin
                m_req = 1; m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic run(input int n, input bit r, input bit hr, input bit ch, input bit up);
        for (int i = 0; i < n; i++)
            cyc(r, hr, ch, 1'($urandom), up, 1'($urandom), 16'($urandom), 8'($urandom));
    endtask

    initial begin
        bit hr_hold;
        reset = 1; hs_req = 0; cpu_halted = 0; hs_write = 0; user_pause = 0; cpu_we = 0;
        hs_address = 0; hs_data_in = 0; cpu_address = 0; cpu_din = 0; ram_dout = 0;
        @(posedge clk_sys); #1;
        run(3, 1, 0, 0, 0);
        run(2, 0, 0, 0, 0);
        // halt arrives five cycles after the request
        run(5, 0, 1, 0, 0);
        run(3, 0, 1, 1, 0);
        // hiscore write while granted, CPU write must be dropped
        cyc(0, 1, 1, 1, 0, 1, 16'h6100, 8'hA5);
        cyc(0, 1, 1, 1, 0, 1, 16'h6101, 8'h5A);
        run(3, 0, 0, 0, 0);
        // halt never comes: forced grant after HT cycles, flag sticky
        run(20, 0, 1, 0, 0);
        run(4, 0, 0, 0, 0);
        run(2, 1, 0, 0, 0);
        run(2, 0, 0, 0, 0);
        // request drops in the same cycle the halt shows up
        run(2, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 16'($urandom), 8'($urandom));
        run(3, 0, 0, 0, 0);
        // long user pause crosses the dim threshold
        run(150, 0, 0, 0, 1);
        run(3, 0, 0, 0, 0);
        // reset in the middle of a grant
        run(4, 0, 1, 1, 0);
        run(1, 1, 1, 1, 0);
        run(2, 0, 0, 0, 0);
        // random traffic
        hr_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) hr_hold = !hr_hold;
            cyc($urandom_range(0, 99) < 2, hr_hold, $urandom_range(0, 9) < 3,
                1'($urandom), $urandom_range(0, 99) < 40, 1'($urandom),
                16'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_sys);
        #2;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
